// File: rtl/clk_enable_gen.sv
// clk_enable_gen: CPU clock-enable strobe generator with run, single-step and burst modes
module clk_enable_gen #(
    parameter int DIV_W       = 25,
    parameter int SEL_W       = 4,
    parameter int STEP        = 2,
    parameter int BURST_W     = 8,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         mode,
    input  logic [SEL_W-1:0]   rate_sel,
    input  logic [BURST_W-1:0] burst_len,
    input  logic               step_in,
    input  logic               hold,
    output logic               clk_en,
    output logic               busy,
    output logic [CNT_W-1:0]   pulse_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] M_RUN   = 2'b00;
    localparam logic [1:0] M_STEP  = 2'b01;
    localparam logic [1:0] M_BURST = 2'b10;

    logic [1:0]             r_state, w_state_nx;
    logic [DIV_W-1:0]       r_cnt, w_tc;
    logic [BURST_W-1:0]     r_rem;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d, r_step_edge;
    logic [31:0]            w_sh;
    logic                   w_wrap, w_count, w_pulse;
    logic                   r_clk_en, r_busy;
    logic [CNT_W-1:0]       r_pulse_count;

    assign clk_en      = r_clk_en;
    assign busy        = r_busy;
    assign pulse_count = r_pulse_count;

    // Terminal count 2^(rate_sel*STEP)-1, saturating at all-ones; >= makes rate shrinks pulse at once
    always_comb begin
        w_sh   = 32'(rate_sel) * 32'(STEP);
        w_tc   = (w_sh < 32'(DIV_W)) ? ~({DIV_W{1'b1}} << w_sh) : '1;
        w_wrap = r_cnt >= w_tc;
    end

    // Synchronise the button and register its rising edge as a one-cycle step request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync      <= '0;
            r_sync_d    <= 1'b0;
            r_step_edge <= 1'b0;
        end else begin
            r_sync      <= SYNC_STAGES'({r_sync, step_in});
            r_sync_d    <= r_sync[SYNC_STAGES-1];
            r_step_edge <= r_sync[SYNC_STAGES-1] & ~r_sync_d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // Next state; hold freezes the state, step requests seen during hold are lost
    always_comb begin
        w_state_nx = r_state;
        if (!hold)
            case (r_state)
                S_IDLE:  w_state_nx = (mode == M_RUN) ? S_RUN :
                                      (mode == M_BURST && r_step_edge && burst_len != '0) ? S_BURST : S_IDLE;
                S_RUN:   w_state_nx = (mode == M_RUN) ? S_RUN : S_IDLE;
                S_BURST: w_state_nx = (mode != M_BURST || (w_wrap && r_rem == BURST_W'(1))) ? S_IDLE : S_BURST;
                default: w_state_nx = S_IDLE;
            endcase
    end

    // Counting enable and next-cycle strobe; a mode change out of RUN/BURST never pulses
    always_comb begin
        w_count = !hold && ((r_state == S_RUN && mode == M_RUN) || (r_state == S_BURST && mode == M_BURST));
        w_pulse = (w_count && w_wrap) || (!hold && r_state == S_IDLE && mode == M_STEP && r_step_edge);
    end

    // Rate counter, burst remainder and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt         <= '0;
            r_rem         <= '0;
            r_clk_en      <= 1'b0;
            r_busy        <= 1'b0;
            r_pulse_count <= '0;
        end else begin
            r_clk_en      <= w_pulse;
            r_busy        <= w_state_nx == S_BURST;
            r_pulse_count <= r_pulse_count + CNT_W'(r_clk_en);
            if (!hold) begin
                r_cnt <= (w_count && !w_wrap) ? r_cnt + DIV_W'(1) : '0;
                r_rem <= (w_state_nx != S_BURST) ? '0 :
                         (r_state == S_BURST) ? r_rem - BURST_W'(w_pulse) : burst_len;
            end
        end
    end
endmodule

// File: tb/tb_clk_enable_gen.sv
// tb_clk_enable_gen: directed and randomized stimulus checked cycle by cycle against a behavioural model
module tb_clk_enable_gen;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  mode = 2'b11;
    logic [3:0]  rate_sel = '0;
    logic [7:0]  burst_len = '0;
    logic        step_in = 1'b0;
    logic        hold = 1'b0;
    logic        clk_en, busy;
    logic [15:0] pulse_count;

    int n_chk = 0;
    int n_fail = 0;

    // model: 0 idle, 1 run, 2 burst
    int     m_st, m_left, m_en, m_pc;
    longint m_ctr;
    bit [3:0] m_ph;

    always #5 clk = ~clk;

    clk_enable_gen dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .rate_sel(rate_sel),
        .burst_len(burst_len), .step_in(step_in), .hold(hold),
        .clk_en(clk_en), .busy(busy), .pulse_count(pulse_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset;
        m_st = 0; m_left = 0; m_en = 0; m_pc = 0; m_ctr = 0; m_ph = '0;
    endtask

    // One board-clock edge of the behaviour described for the block
    task automatic model_step;
        longint tc;
        int     r;
        bit     edge_seen;
        r  = int'(rate_sel);
        tc = (r * 2 < 25) ? (longint'(1) << (r * 2)) - 1 : (longint'(1) << 25) - 1;
        edge_seen = m_ph[2] && !m_ph[3];
        m_ph = {m_ph[2:0], step_in};
        m_pc = (m_pc + m_en) % 65536;
        if (hold) m_en = 0;
        else case (m_st)
            0: begin
                m_en = (mode == 2'b01 && edge_seen) ? 1 : 0;
                if (mode == 2'b00) m_st = 1;
                else if (mode == 2'b10 && edge_seen && burst_len != 0) begin
                    m_st = 2; m_left = int'(burst_len); m_ctr = 0;
                end
            end
            1: begin
                if (mode != 2'b00) begin m_st = 0; m_en = 0; m_ctr = 0; end
                else if (m_ctr >= tc) begin m_en = 1; m_ctr = 0; end
                else begin m_en = 0; m_ctr++; end
            end
            default: begin
                if (mode != 2'b10) begin m_st = 0; m_en = 0; m_ctr = 0; m_left = 0; end
                else if (m_ctr >= tc) begin
                    m_en = 1; m_ctr = 0; m_left--;
                    if (m_left == 0) m_st = 0;
                end else begin m_en = 0; m_ctr++; end
            end
        endcase
    endtask

    // Called at a falling edge: compare, drive new inputs, advance model past the rising edge
    task automatic cyc(input logic [1:0] md, input int rs, input int bl, input logic st, input logic hd);
        check("clk_en", clk_en, m_en);
        check("busy", busy, m_st == 2);
        check("pulse_count", pulse_count, m_pc);
        mode = md; rate_sel = rs[3:0]; burst_len = bl[7:0]; step_in = st; hold = hd;
        @(posedge clk);
        model_step;
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [1:0] md, input int rs, input int bl, input logic st, input logic hd);
        repeat (n) cyc(md, rs, bl, st, hd);
    endtask

    // Asynchronous reset between edges; outputs must clear without waiting for a clock
    task automatic do_reset;
        #2 reset_n = 1'b0;
        model_reset;
        #1;
        check("rst_clk_en", clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_pulse_count", pulse_count, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic st, hd;
        int   sl, len, md, rs, bl, pick;
        model_reset;
        @(negedge clk);
        check("init_clk_en", clk_en, 0);
        check("init_busy", busy, 0);
        check("init_pulse_count", pulse_count, 0);
        reset_n = 1'b1;
        run(12, 2'b00, 0, 0, 0, 0);
        do_reset;
        run(12, 2'b00, 0, 0, 0, 0);
        run(11, 2'b00, 1, 0, 0, 0);
        run(6, 2'b00, 0, 0, 0, 0);
        run(4, 2'b11, 0, 0, 0, 0);
        run(20, 2'b01, 0, 0, 1, 0);
        run(10, 2'b01, 0, 0, 0, 0);
        run(20, 2'b10, 1, 3, 1, 0);
        run(4, 2'b10, 1, 3, 0, 0);
        run(4, 2'b10, 1, 3, 1, 0);
        run(12, 2'b10, 1, 3, 0, 0);
        run(10, 2'b10, 1, 0, 1, 0);
        run(6, 2'b10, 1, 0, 0, 0);
        run(4, 2'b10, 1, 3, 1, 0);
        run(5, 2'b10, 1, 3, 0, 0);
        run(50, 2'b10, 1, 3, 0, 1);
        run(20, 2'b10, 1, 3, 0, 0);
        run(4, 2'b10, 1, 5, 1, 0);
        run(6, 2'b10, 1, 5, 0, 0);
        run(8, 2'b11, 1, 5, 0, 0);
        run(4, 2'b10, 1, 5, 1, 0);
        run(6, 2'b10, 1, 5, 0, 0);
        do_reset;
        run(8, 2'b10, 1, 5, 0, 0);
        st = 1'b0; hd = 1'b0; sl = 5;
        for (int s = 0; s < 120; s++) begin
            len  = int'($urandom_range(10, 60));
            pick = int'($urandom_range(0, 9));
            md   = (pick < 3) ? 0 : (pick < 5) ? 1 : (pick < 9) ? 2 : 3;
            rs   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 15)) : int'($urandom_range(0, 2));
            bl   = int'($urandom_range(0, 5));
            if ($urandom_range(0, 14) == 0) do_reset;
            for (int c = 0; c < len; c++) begin
                if (sl == 0) begin
                    st = ~st;
                    sl = st ? int'($urandom_range(1, 8)) : int'($urandom_range(4, 15));
                end
                sl--;
                if ($urandom_range(0, 99) < 4) hd = ~hd;
                if ($urandom_range(0, 49) == 0) rs = int'($urandom_range(0, 2));
                cyc(2'(md), rs, bl, st, hd);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
